// File: rtl/fetch_unit.sv
// Instruction-fetch stage for the single-cycle LEGv8 core.
// Keeps the 64-bit PC, drives the instruction-memory address straight from
// it, and registers the returned instruction plus its PC into an IF/ID slot
// offered to decode. Unconditional B is resolved here. Taken branches from
// later stages (redirects) and halt requests arrive from downstream.
//
// Handshake (IF/ID slot): out_valid/out_instruction/out_pc form the slot.
// A transfer happens on a rising edge where out_valid && out_ready are both
// high. While out_valid is high and out_ready is low, the slot contents are
// held stable. A redirect in the same cycle cancels the transfer: the slot is
// flushed and it is not counted as delivered.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000,
  parameter int          COUNT_W  = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  output logic [63:0]        imem_address,
  input  logic [31:0]        imem_instruction,
  input  logic               redirect_valid,
  input  logic [63:0]        redirect_target,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instruction,
  output logic [63:0]        out_pc,
  output logic [COUNT_W-1:0] fetch_count,
  output logic               halted,
  output logic [1:0]         state_dbg
);

  // BOOT is a one-cycle settling state after reset; HALTED freezes the PC.
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Opcode of the unconditional B instruction (bits 31:26).
  localparam logic [5:0] OP_B = 6'b000101;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] pc;
  logic [63:0] next_pc;
  logic [63:0] b_offset;
  logic [63:0] redirect_pc;
  logic        is_b;
  logic        redirect_take;
  logic        slot_load;
  logic        slot_accept;

  // PC register is the memory address; no extra logic in between.
  assign imem_address = pc;
  assign state_dbg    = state;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: BOOT always leaves after one cycle; a redirect without
  // halt is the only way out of HALTED.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT:   state_nxt = halt ? ST_HALTED : ST_RUN;
      ST_RUN:    if (halt) state_nxt = ST_HALTED;
      ST_HALTED: if (redirect_valid && !halt) state_nxt = ST_RUN;
      default:   state_nxt = ST_BOOT;
    endcase
  end

  // Output/control decode: load, accept and redirect qualifiers for this cycle.
  always_comb begin
    halted        = (state == ST_HALTED);
    // Redirects are ignored during BOOT; nothing can be in flight yet.
    redirect_take = redirect_valid && (state != ST_BOOT);
    // A load needs RUN, no flush, and a slot that is empty or draining now.
    slot_load     = (state == ST_RUN) && !redirect_valid &&
                    (!out_valid || out_ready);
    // Delivered to decode; a concurrent redirect cancels the delivery.
    slot_accept   = out_valid && out_ready && !redirect_valid;
  end

  // Branch-offset decode and next sequential/branch PC (modulo 2^64).
  always_comb begin
    is_b        = (imem_instruction[31:26] == OP_B);
    b_offset    = {{36{imem_instruction[25]}}, imem_instruction[25:0], 2'b00};
    next_pc     = pc + (is_b ? b_offset : 64'd4);
    // Instructions are word aligned, so the two low target bits are dropped.
    redirect_pc = redirect_target & ~64'd3;
  end

  // Program counter: redirect wins, otherwise advance on every slot load.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc <= RESET_PC;
    end else if (redirect_take) begin
      pc <= redirect_pc;
    end else if (slot_load) begin
      pc <= next_pc;
    end
  end

  // IF/ID slot: flush on redirect, fill on load, empty on accept-without-load.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid       <= 1'b0;
      out_instruction <= 32'd0;
      out_pc          <= 64'd0;
    end else if (redirect_take) begin
      out_valid <= 1'b0;
    end else if (slot_load) begin
      out_valid       <= 1'b1;
      out_instruction <= imem_instruction;
      out_pc          <= pc;
    end else if (slot_accept) begin
      out_valid <= 1'b0;
    end
  end

  // Delivered-instruction counter; wraps naturally at 2^COUNT_W.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_count <= '0;
    end else if (slot_accept) begin
      fetch_count <= fetch_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed walk through the program, stall,
// redirect, halt and async-reset scenarios, then a randomized phase, all
// compared each cycle against a transaction-level reference model.
module tb_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic [63:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [63:0] out_pc;
  logic [31:0] fetch_count;
  logic        halted;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  // Program memory, word addressed, aliased every 1 KiB.
  logic [31:0] mem [256];
  assign imem_instruction = mem[imem_address[9:2]];

  // Reference model state.
  logic [63:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_opc;
  logic [31:0] m_count;
  bit          m_boot;
  bit          m_halt;

  fetch_unit #(.RESET_PC(64'h0), .COUNT_W(32)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .halt             (halt),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .fetch_count      (fetch_count),
    .halted           (halted),
    .state_dbg        (state_dbg)
  );

  // Clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 64'h0;
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_opc   = 64'h0;
    m_count = 32'h0;
    m_boot  = 1'b1;
    m_halt  = 1'b0;
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    logic [31:0] word;
    bit          delivered;
    bit          can_fetch;
    longint      offset;
    word      = mem[m_pc[9:2]];
    delivered = m_valid && out_ready && !redirect_valid;
    can_fetch = !m_boot && !m_halt && !redirect_valid && (!m_valid || out_ready);
    if (delivered) m_count = m_count + 1;
    if (m_boot) begin
      m_boot = 1'b0;
      m_halt = halt;
    end else if (redirect_valid) begin
      m_pc    = {redirect_target[63:2], 2'b00};
      m_valid = 1'b0;
      m_halt  = halt;
    end else begin
      if (can_fetch) begin
        m_instr = word;
        m_opc   = m_pc;
        m_valid = 1'b1;
        if (word[31:26] == 6'b000101) begin
          offset = longint'($signed(word[25:0])) * 4;
          m_pc   = m_pc + 64'(offset);
        end else begin
          m_pc = m_pc + 64'd4;
        end
      end else if (delivered) begin
        m_valid = 1'b0;
      end
      if (halt) m_halt = 1'b1;
    end
  endtask

  task automatic compare_model();
    logic [1:0] exp_dbg;
    exp_dbg = m_boot ? 2'd0 : (m_halt ? 2'd2 : 2'd1);
    check("m_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check("m_instr", 64'(out_instruction), 64'(m_instr));
      check("m_pc_out", out_pc, m_opc);
    end
    check("m_addr", imem_address, m_pc);
    check("m_count", 64'(fetch_count), 64'(m_count));
    check("m_halted", 64'(halted), 64'(m_halt));
    check("m_state", 64'(state_dbg), 64'(exp_dbg));
  endtask

  // One clock: model steps on current inputs, DUT sampled 1ns after the edge.
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    compare_model();
  endtask

  task automatic expect_slot(input string tag, input logic [63:0] pc, input logic [31:0] ins);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_ins"}, 64'(out_instruction), 64'(ins));
  endtask

  task automatic fill_mem();
    int          o;
    logic [31:0] r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      if (r[31:26] == 6'b000101) r[31] = 1'b1;
      mem[i] = r;
    end
    for (int i = 16; i < 256; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        o = int'($urandom_range(0, 16)) - 8;
        mem[i] = {6'b000101, o[25:0]};
      end
    end
    mem[0]  = 32'h91002041;
    mem[1]  = 32'hCB000842;
    mem[2]  = 32'h8A1F0C63;
    mem[3]  = 32'hAA020020;
    mem[4]  = 32'hF8400C21;
    mem[5]  = 32'hF8000C20;
    mem[6]  = 32'h8B020020;
    mem[7]  = 32'hCB000842;
    mem[8]  = 32'h91000421;
    mem[9]  = 32'hD1000421;
    mem[10] = 32'h17FFFFFD;
  endtask

  initial begin
    RESET           = 1'b1;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 64'h0;
    halt            = 1'b0;
    fill_mem();
    model_reset();

    // Reset state.
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(fetch_count), 64'd0);
    check("rst_addr", imem_address, 64'h0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_pc", out_pc, 64'h0);
    check("rst_ins", 64'(out_instruction), 64'h0);
    #10;
    RESET     = 1'b0;
    out_ready = 1'b1;

    // First edge after release: still booting.
    tick();
    check("boot_valid", 64'(out_valid), 64'd0);
    tick();
    expect_slot("s0", 64'h0, 32'h91002041);
    check("s0_count", 64'(fetch_count), 64'd0);
    tick();
    expect_slot("s4", 64'h4, 32'hCB000842);
    check("s4_count", 64'(fetch_count), 64'd1);
    tick();
    expect_slot("s8", 64'h8, 32'h8A1F0C63);
    check("s8_count", 64'(fetch_count), 64'd2);
    tick();
    tick();
    expect_slot("s10", 64'h10, 32'hF8400C21);

    // Stall for three cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_slot("stall", 64'h10, 32'hF8400C21);
      check("stall_addr", imem_address, 64'h14);
      check("stall_count", 64'(fetch_count), 64'd4);
    end
    out_ready = 1'b1;
    tick();
    expect_slot("s14", 64'h14, 32'hF8000C20);
    check("s14_count", 64'(fetch_count), 64'd5);

    // Run up to the backward B and follow it without a bubble.
    for (int i = 0; i < 5; i++) tick();
    expect_slot("sb", 64'h28, 32'h17FFFFFD);
    tick();
    expect_slot("sb_tgt", 64'h1C, 32'hCB000842);
    check("sb_count", 64'(fetch_count), 64'd11);

    // Redirect while a valid slot is being accepted: dropped, not counted.
    redirect_valid  = 1'b1;
    redirect_target = 64'h2A;
    tick();
    check("rd_valid", 64'(out_valid), 64'd0);
    check("rd_count", 64'(fetch_count), 64'd11);
    check("rd_addr", imem_address, 64'h28);
    redirect_valid = 1'b0;
    tick();
    expect_slot("rd_slot", 64'h28, 32'h17FFFFFD);

    // Back to 0x0, then halt when pc reaches 0x8.
    redirect_valid  = 1'b1;
    redirect_target = 64'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check("pre_halt_addr", imem_address, 64'h8);
    halt = 1'b1;
    tick();
    expect_slot("halt_slot", 64'h8, 32'h8A1F0C63);
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_addr", imem_address, 64'hC);
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halted_valid", 64'(out_valid), 64'd0);
      check("halted_addr", imem_address, 64'hC);
      check("halted_flag", 64'(halted), 64'd1);
    end
    redirect_valid  = 1'b1;
    redirect_target = 64'h0;
    tick();
    check("resume_flag", 64'(halted), 64'd0);
    redirect_valid = 1'b0;
    tick();
    expect_slot("resume", 64'h0, 32'h91002041);

    // Async reset in the middle of a stall.
    out_ready = 1'b0;
    tick();
    tick();
    #2;
    RESET = 1'b1;
    #1;
    model_reset();
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(fetch_count), 64'd0);
    check("arst_pc", out_pc, 64'h0);
    check("arst_addr", imem_address, 64'h0);
    check("arst_halted", 64'(halted), 64'd0);
    #10;
    RESET     = 1'b0;
    out_ready = 1'b1;
    tick();
    check("arst_boot", 64'(out_valid), 64'd0);
    tick();
    expect_slot("arst_s0", 64'h0, 32'h91002041);

    // Randomized phase against the model, including wrap near 2^64.
    for (int i = 0; i < 600; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      halt           = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_target = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31));
      else
        redirect_target = 64'($urandom_range(0, 1023));
      tick();
    end
    redirect_valid = 1'b0;
    halt           = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle LEGv8 core.
- Holds the 64-bit program counter and drives the combinational instruction memory address.
- Registers the returned 32-bit instruction plus its PC into an IF/ID output slot with a valid/ready handshake toward decode.
- Resolves unconditional B locally. Accepts redirects (CBZ/CBNZ and other resolved branches) and a halt request from later stages.

Parameters:
RESET_PC  64'h0000  PC value loaded on reset
COUNT_W  32  width of delivered-instruction counter

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
imem_address  output  64  address to instruction memory; equals pc register (combinational)
imem_instruction  input  32  instruction returned by memory, same cycle
redirect_valid  input  1  taken branch from later stage; flush and load new PC
redirect_target  input  64  branch target PC
halt  input  1  stop fetching after current cycle
out_valid  output  1  IF/ID slot holds a valid instruction
out_ready  input  1  decode accepts slot this cycle
out_instruction  output  32  fetched instruction
out_pc  output  64  PC of out_instruction
fetch_count  output  COUNT_W  number of instructions accepted by decode
halted  output  1  state == HALTED

Behaviour:
- States: BOOT, RUN, HALTED.
- Reset (async, any time, including mid-stall or mid-redirect) forces:
  - pc=RESET_PC, state=BOOT
  - out_valid=0, out_instruction=0, out_pc=0
  - fetch_count=0, halted=0
- BOOT:
  - No load.
  - Next state RUN, or HALTED if halt=1.
- Slot load condition: state==RUN && redirect_valid==0 && (out_valid==0 || out_ready==1).
- On load:
  - out_instruction<=imem_instruction, out_pc<=pc, out_valid<=1.
  - pc<=next_pc.
- next_pc:
  - Unconditional B (imem_instruction[31:26]==6'b000101): next_pc = pc + (sign_extend(imem_instruction[25:0])<<2).
  - Otherwise next_pc = pc + 4.
  - All arithmetic is 64-bit modulo 2^64 (wrap, no error).
- B is still delivered on out_*. Decode treats it as a no-op for PC purposes.
- Accept without load: out_valid && out_ready && no load this cycle -> out_valid<=0.
- Stall: out_valid && !out_ready -> out_* and pc hold unchanged.
- Redirect (redirect_valid=1), highest priority, any state except BOOT:
  - pc<=redirect_target with bits[1:0] forced to 0.
  - out_valid<=0 unconditionally (pending slot dropped even if out_ready=1 that cycle; fetch_count NOT incremented for it).
  - If state==HALTED and halt==0 -> state RUN.
- Halt (halt=1 in RUN):
  - Next state HALTED. A load permitted this same cycle still occurs.
  - In HALTED: pc frozen, no loads. A pending valid slot remains and completes its handshake normally.
- halt and redirect_valid in the same cycle: redirect updates pc and flushes; state becomes/stays HALTED.
- fetch_count increments by 1 on every cycle with out_valid && out_ready && !redirect_valid. Wraps at 2^COUNT_W.
- Latency:
  - Instruction at pc appears on out_* one clock after pc is presented.
  - Throughput 1 instruction/cycle with out_ready held high.
- out_* change only on clock edges or reset. imem_address changes only with pc.

Test Plan:
- Reset then out_ready=1 against program memory -> out_valid rises 2nd edge after reset release with out_pc=0x0, out_instruction=0x91002041. Next cycle 0x4/0xCB000842. Then 0x8/0x8A1F0C63. fetch_count increments each cycle.
- Run to pc=0x28 (0x17FFFFFD, B imm=-3) -> slot shows 0x28/0x17FFFFFD. Next slot is out_pc=0x1C/0xCB000842 with no bubble.
- Hold out_ready=0 for 3 cycles while slot=0x10/0xF8400C21 -> out_* and imem_address=0x14 unchanged, fetch_count frozen. Release -> 0x14/0xF8000C20 next cycle.
- redirect_valid=1, target=0x2A while slot valid and out_ready=1 -> out_valid=0 next cycle, fetch_count unchanged. Following slot is 0x28/0x17FFFFFD (low bits cleared).
- halt pulse at pc=0x8 -> slot 0x8 delivered, halted=1, imem_address stays 0xC, no further valid. redirect to 0x0 with halt=0 -> resumes at 0x0.
- Assert RESET asynchronously mid-stall (between edges) -> out_valid, fetch_count, out_pc drop to 0 immediately and imem_address=RESET_PC. Deassert -> sequence restarts from 0x0.
